// File: rtl/defines_pkg.sv
// Shared sizing constants and FSM state type for the hazard scoreboard
// and its per-register pending-write counters.
package defines_pkg;

   localparam int NUM_REGS  = 8;
   localparam int REG_IDX_W = 3;
   localparam int SB_CNT_W  = 2;

   localparam logic [SB_CNT_W-1:0] SB_CNT_ZERO = '0;
   localparam logic [SB_CNT_W-1:0] SB_CNT_ONE  = SB_CNT_W'(1);
   localparam logic [SB_CNT_W-1:0] SB_CNT_MAX  = '1;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } sb_state_t;

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register: saturating up/down
// with a sticky underflow flag raised by a retire against an empty count.
module sb_counter
   import defines_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                inc,
   input  logic                dec,
   output logic [SB_CNT_W-1:0] count,
   output logic [SB_CNT_W-1:0] count_next,
   output logic                underflow
);

   logic [SB_CNT_W-1:0] count_q, count_d;
   logic                underflow_q, underflow_d;

   // Simultaneous issue and retire on the same register cancel out.
   always_comb begin
      count_d     = count_q;
      underflow_d = underflow_q;
      if (inc && !dec) begin
         if (count_q != SB_CNT_MAX) begin
            count_d = count_q + SB_CNT_ONE;
         end
      end else if (dec && !inc) begin
         if (count_q == SB_CNT_ZERO) begin
            underflow_d = 1'b1;
         end else begin
            count_d = count_q - SB_CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= SB_CNT_ZERO;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   assign count      = count_q;
   assign count_next = count_d;
   assign underflow  = underflow_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for decode: RAW/saturation stalls, HALT drain.
// HAZARD_SCOREBOARD_BYPASS_EN lets a same-cycle final retire release a RAW stall.
module hazard_scoreboard
   import defines_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_valid_p2,
   input  logic [REG_IDX_W-1:0] rs_index_p2,
   input  logic [REG_IDX_W-1:0] rt_index_p2,
   input  logic [REG_IDX_W-1:0] rd_index_p2,
   input  logic [2:0]           src_use_p2,
   input  logic [REG_IDX_W-1:0] dest_reg_p2,
   input  logic                 dest_wr_p2,
   input  logic                 halt_p2,
   input  logic                 retire_valid_p5,
   input  logic [REG_IDX_W-1:0] retire_index_p5,
   output logic                 stall_p2,
   output logic                 issue_ok_p2,
   output logic [NUM_REGS-1:0]  busy_mask,
   output logic                 halted,
   output logic                 underflow_err,
   output sb_state_t            dbg_state
);

   // Handshake: a uop is accepted in the cycle issue_valid_p2 & ~stall_p2;
   // while stalled, decode keeps presenting the same uop unchanged.

   logic [SB_CNT_W-1:0]  count      [NUM_REGS];
   logic [SB_CNT_W-1:0]  count_next [NUM_REGS];
   logic [NUM_REGS-1:0]  inc, dec, uflow;
   logic [REG_IDX_W-1:0] src_idx [3];
   logic                 raw_hazard, sat_hazard;

   sb_state_t           state_q, state_d;
   logic [NUM_REGS-1:0] busy_mask_q, busy_mask_d;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
      sb_counter u_cnt (
         .clk        (clk),
         .rst        (rst),
         .inc        (inc[g]),
         .dec        (dec[g]),
         .count      (count[g]),
         .count_next (count_next[g]),
         .underflow  (uflow[g])
      );
   end

   assign src_idx[0] = rs_index_p2;
   assign src_idx[1] = rt_index_p2;
   assign src_idx[2] = rd_index_p2;

   always_comb begin
      raw_hazard = 1'b0;
      for (int s = 0; s < 3; s++) begin
         if (src_use_p2[s] && count[src_idx[s]] != SB_CNT_ZERO) begin
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
            // The last outstanding write retiring this cycle is forwarded.
            if (!(count[src_idx[s]] == SB_CNT_ONE && retire_valid_p5 &&
                  retire_index_p5 == src_idx[s])) begin
               raw_hazard = 1'b1;
            end
`else
            raw_hazard = 1'b1;
`endif
         end
      end
   end

   assign sat_hazard = dest_wr_p2 && (count[dest_reg_p2] == SB_CNT_MAX);

   always_comb begin
      stall_p2    = (issue_valid_p2 && raw_hazard) || sat_hazard ||
                    (state_q == DRAIN) || (state_q == HALTED);
      issue_ok_p2 = issue_valid_p2 && !stall_p2;
      halted      = (state_q == HALTED);
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         inc[i]         = issue_ok_p2 && dest_wr_p2 && (dest_reg_p2 == REG_IDX_W'(i));
         dec[i]         = retire_valid_p5 && (retire_index_p5 == REG_IDX_W'(i));
         busy_mask_d[i] = (count_next[i] != SB_CNT_ZERO);
      end
   end

   // A HALT accepted out of STALL (stall just cleared) must still drain.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (issue_ok_p2 && halt_p2) state_d = DRAIN;
            else if (stall_p2)          state_d = STALL;
         end
         STALL: begin
            if (issue_ok_p2 && halt_p2) state_d = DRAIN;
            else if (!stall_p2)         state_d = RUN;
         end
         DRAIN: begin
            if (busy_mask_q == '0) state_d = HALTED;
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         busy_mask_q <= '0;
      end else begin
         state_q     <= state_d;
         busy_mask_q <= busy_mask_d;
      end
   end

   assign busy_mask     = busy_mask_q;
   assign underflow_err = |uflow;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard/drain/reset
// scenarios followed by a randomized issue/retire run against a count model.
module tb_hazard_scoreboard;
   import defines_pkg::*;

`ifdef HAZARD_SCOREBOARD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [1:0] S_RUN = 2'd0, S_STALL = 2'd1, S_DRAIN = 2'd2, S_HALTED = 2'd3;

   logic       clk, rst;
   logic       issue_valid_p2;
   logic [2:0] rs_index_p2, rt_index_p2, rd_index_p2, src_use_p2, dest_reg_p2;
   logic       dest_wr_p2, halt_p2, retire_valid_p5;
   logic [2:0] retire_index_p5;
   logic       stall_p2, issue_ok_p2, halted, underflow_err;
   logic [7:0] busy_mask;
   sb_state_t  dbg_state;
   logic [1:0] st_obs;

   assign st_obs = dbg_state;

   hazard_scoreboard dut (
      .clk             (clk),
      .rst             (rst),
      .issue_valid_p2  (issue_valid_p2),
      .rs_index_p2     (rs_index_p2),
      .rt_index_p2     (rt_index_p2),
      .rd_index_p2     (rd_index_p2),
      .src_use_p2      (src_use_p2),
      .dest_reg_p2     (dest_reg_p2),
      .dest_wr_p2      (dest_wr_p2),
      .halt_p2         (halt_p2),
      .retire_valid_p5 (retire_valid_p5),
      .retire_index_p5 (retire_index_p5),
      .stall_p2        (stall_p2),
      .issue_ok_p2     (issue_ok_p2),
      .busy_mask       (busy_mask),
      .halted          (halted),
      .underflow_err   (underflow_err),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
      end
   endtask

   task automatic pop_check(input string tag, input logic [7:0] obs);
      if (exp_q.size() == 0) check({tag, ".empty_q"}, obs, ~obs);
      else                   check(tag, obs, exp_q.pop_front());
   endtask

   // ctl byte = {stall, issue_ok, halted, underflow, state, 2'b00}
   task automatic push_exp(input logic st, input logic ok, input logic hl, input logic uf,
                           input logic [1:0] state, input logic [7:0] busy);
      exp_q.push_back({st, ok, hl, uf, state, 2'b00});
      exp_q.push_back(busy);
   endtask

   task automatic sample(input string tag);
      #1;
      pop_check({tag, ".ctl"}, {stall_p2, issue_ok_p2, halted, underflow_err, st_obs, 2'b00});
      pop_check({tag, ".busy"}, busy_mask);
   endtask

   // ---------------- drivers ----------------
   task automatic idle_inputs();
      issue_valid_p2  = 1'b0;
      rs_index_p2     = '0;
      rt_index_p2     = '0;
      rd_index_p2     = '0;
      src_use_p2      = '0;
      dest_reg_p2     = '0;
      dest_wr_p2      = 1'b0;
      halt_p2         = 1'b0;
      retire_valid_p5 = 1'b0;
      retire_index_p5 = '0;
   endtask

   task automatic next_step();
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic uop(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                      input logic [2:0] use_m, input logic [2:0] dr, input logic dw,
                      input logic hlt);
      issue_valid_p2 = 1'b1;
      rs_index_p2    = rs;
      rt_index_p2    = rt;
      rd_index_p2    = rd;
      src_use_p2     = use_m;
      dest_reg_p2    = dr;
      dest_wr_p2     = dw;
      halt_p2        = hlt;
   endtask

   task automatic wr(input logic [2:0] dr);
      uop(3'd0, 3'd0, 3'd0, 3'b000, dr, 1'b1, 1'b0);
   endtask

   task automatic retire(input logic [2:0] idx);
      retire_valid_p5 = 1'b1;
      retire_index_p5 = idx;
   endtask

   // ---------------- random phase with count model ----------------
   task automatic random_phase(input int n);
      int         mcnt[8];
      logic [1:0] mstate;
      logic [2:0] idx[3];
      logic       e_stall, e_ok;
      logic [7:0] e_busy;
      for (int r = 0; r < 8; r++) mcnt[r] = 0;
      mstate = S_RUN;
      for (int k = 0; k < n; k++) begin
         next_step();
         if ($urandom_range(0, 1) == 1) begin
            uop(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'b0);
         end
         retire_index_p5 = 3'($urandom_range(0, 7));
         retire_valid_p5 = ($urandom_range(0, 1) == 1) && (mcnt[retire_index_p5] != 0);
         idx[0] = rs_index_p2;
         idx[1] = rt_index_p2;
         idx[2] = rd_index_p2;
         e_stall = 1'b0;
         for (int s = 0; s < 3; s++) begin
            if (issue_valid_p2 && src_use_p2[s] && mcnt[idx[s]] != 0 &&
                !(BYP && mcnt[idx[s]] == 1 && retire_valid_p5 && retire_index_p5 == idx[s]))
               e_stall = 1'b1;
         end
         if (dest_wr_p2 && mcnt[dest_reg_p2] == 3) e_stall = 1'b1;
         e_ok = issue_valid_p2 && !e_stall;
         for (int r = 0; r < 8; r++) e_busy[r] = (mcnt[r] != 0);
         push_exp(e_stall, e_ok, 1'b0, 1'b0, mstate, e_busy);
         sample("rand");
         if (!(e_ok && dest_wr_p2 && retire_valid_p5 && dest_reg_p2 == retire_index_p5)) begin
            if (e_ok && dest_wr_p2) mcnt[dest_reg_p2]++;
            if (retire_valid_p5)    mcnt[retire_index_p5]--;
         end
         mstate = e_stall ? S_STALL : S_RUN;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);

      next_step(); rst = 1'b0;
      push_exp(0, 0, 0, 0, S_RUN, 8'h00); sample("reset");

      // RAW on r3: stall until retire, release N+1 (N with bypass)
      next_step(); wr(3'd3);
      push_exp(0, 1, 0, 0, S_RUN, 8'h00); sample("raw_wr");
      next_step(); uop(3'd3, 3'd0, 3'd0, 3'b001, 3'd0, 1'b0, 1'b0);
      push_exp(1, 0, 0, 0, S_RUN, 8'h08); sample("raw_stall0");
      next_step(); uop(3'd3, 3'd0, 3'd0, 3'b001, 3'd0, 1'b0, 1'b0);
      push_exp(1, 0, 0, 0, S_STALL, 8'h08); sample("raw_stall1");
      next_step(); uop(3'd3, 3'd0, 3'd0, 3'b001, 3'd0, 1'b0, 1'b0); retire(3'd3);
      push_exp(!BYP, BYP, 0, 0, S_STALL, 8'h08); sample("raw_retire");
      next_step(); uop(3'd3, 3'd0, 3'd0, 3'b001, 3'd0, 1'b0, 1'b0);
      push_exp(0, 1, 0, 0, BYP ? S_RUN : S_STALL, 8'h00); sample("raw_release");
      next_step();
      push_exp(0, 0, 0, 0, S_RUN, 8'h00); sample("raw_idle");

      // saturation on r5
      next_step(); wr(3'd5); push_exp(0, 1, 0, 0, S_RUN, 8'h00); sample("sat_w1");
      next_step(); wr(3'd5); push_exp(0, 1, 0, 0, S_RUN, 8'h20); sample("sat_w2");
      next_step(); wr(3'd5); push_exp(0, 1, 0, 0, S_RUN, 8'h20); sample("sat_w3");
      next_step(); wr(3'd5); push_exp(1, 0, 0, 0, S_RUN, 8'h20); sample("sat_w4");
      next_step(); wr(3'd5); retire(3'd5);
      push_exp(1, 0, 0, 0, S_STALL, 8'h20); sample("sat_retire");
      next_step(); wr(3'd5); push_exp(0, 1, 0, 0, S_STALL, 8'h20); sample("sat_issue");
      next_step(); wr(3'd5); push_exp(1, 0, 0, 0, S_RUN, 8'h20); sample("sat_again");
      next_step(); retire(3'd5); push_exp(0, 0, 0, 0, S_STALL, 8'h20); sample("sat_r1");
      next_step(); retire(3'd5); push_exp(0, 0, 0, 0, S_RUN, 8'h20); sample("sat_r2");
      next_step(); retire(3'd5); push_exp(0, 0, 0, 0, S_RUN, 8'h20); sample("sat_r3");
      next_step(); push_exp(0, 0, 0, 0, S_RUN, 8'h00); sample("sat_empty");

      // issue and retire r2 in the same cycle
      next_step(); wr(3'd2); push_exp(0, 1, 0, 0, S_RUN, 8'h00); sample("same_w");
      next_step(); wr(3'd2); retire(3'd2);
      push_exp(0, 1, 0, 0, S_RUN, 8'h04); sample("same_both");
      next_step(); push_exp(0, 0, 0, 0, S_RUN, 8'h04); sample("same_hold");
      next_step(); retire(3'd2); push_exp(0, 0, 0, 0, S_RUN, 8'h04); sample("same_r");
      next_step(); push_exp(0, 0, 0, 0, S_RUN, 8'h00); sample("same_empty");

      // underflow on r7
      next_step(); retire(3'd7); push_exp(0, 0, 0, 0, S_RUN, 8'h00); sample("uf_retire");
      next_step(); push_exp(0, 0, 0, 1, S_RUN, 8'h00); sample("uf_sticky");

      // HALT with r1, r4 pending
      next_step(); wr(3'd1); push_exp(0, 1, 0, 1, S_RUN, 8'h00); sample("halt_w1");
      next_step(); wr(3'd4); push_exp(0, 1, 0, 1, S_RUN, 8'h02); sample("halt_w4");
      next_step(); uop(3'd0, 3'd0, 3'd0, 3'b000, 3'd0, 1'b0, 1'b1);
      push_exp(0, 1, 0, 1, S_RUN, 8'h12); sample("halt_issue");
      next_step(); wr(3'd0); push_exp(1, 0, 0, 1, S_DRAIN, 8'h12); sample("drain_blk");
      next_step(); wr(3'd0); retire(3'd1);
      push_exp(1, 0, 0, 1, S_DRAIN, 8'h12); sample("drain_r1");
      next_step(); wr(3'd0); retire(3'd4);
      push_exp(1, 0, 0, 1, S_DRAIN, 8'h10); sample("drain_r4");
      next_step(); wr(3'd0); push_exp(1, 0, 0, 1, S_DRAIN, 8'h00); sample("drain_zero");
      next_step(); wr(3'd0); push_exp(1, 0, 1, 1, S_HALTED, 8'h00); sample("halted");
      next_step(); push_exp(1, 0, 1, 1, S_HALTED, 8'h00); sample("halted_idle");

      // reset out of HALTED, then reset mid-DRAIN with counts pending
      next_step(); rst = 1'b1; push_exp(1, 0, 1, 1, S_HALTED, 8'h00); sample("rst_in_halt");
      next_step(); rst = 1'b0; push_exp(0, 0, 0, 0, S_RUN, 8'h00); sample("rst_cleared");
      next_step(); wr(3'd6); push_exp(0, 1, 0, 0, S_RUN, 8'h00); sample("rd_w6");
      next_step(); uop(3'd0, 3'd0, 3'd0, 3'b000, 3'd0, 1'b0, 1'b1);
      push_exp(0, 1, 0, 0, S_RUN, 8'h40); sample("rd_halt");
      next_step(); rst = 1'b1; wr(3'd6); retire(3'd0);
      push_exp(1, 0, 0, 0, S_DRAIN, 8'h40); sample("rd_rst");
      next_step(); rst = 1'b0; push_exp(0, 0, 0, 0, S_RUN, 8'h00); sample("rd_after");

      random_phase(300);

      if (exp_q.size() != 0) check("queue_drained", 8'(exp_q.size()), 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
